// File: rtl/capture_sequencer_if.sv
// Bundles the camera byte stream, capture controls and frame-buffer write bus
// of capture_sequencer. The DUT uses the slave view, the camera/host side the master view.
interface capture_sequencer_if;
  logic        reg_conf_finish;
  logic        cap_vsync;
  logic        cap_href;
  logic [7:0]  cap_d;
  logic [1:0]  frame_skip;
  logic        single_shot;
  logic        arm;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  modport master (
    output reg_conf_finish, cap_vsync, cap_href, cap_d, frame_skip, single_shot, arm,
    input  wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );

  modport slave (
    input  reg_conf_finish, cap_vsync, cap_href, cap_d, frame_skip, single_shot, arm,
    output wr_en, wr_addr, wr_data, frame_done, frame_err, busy
  );
endinterface

// File: rtl/capture_sequencer.sv
// Frame capture sequencer: packs an RGB565 camera byte stream into RGB444 frame-buffer
// writes, with frame skipping, single-shot hold and per-frame good/bad reporting.
module capture_sequencer #(
  parameter int H_BYTES = 640,
  parameter int V_LINES = 240
) (
  input logic                cap_pclk,
  input logic                reg_conf_rst,
  capture_sequencer_if.slave bus
);
  localparam int          PIX_TOTAL = (H_BYTES / 2) * V_LINES;
  localparam logic [16:0] ADDR_MAX  = 17'(PIX_TOTAL - 1);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, SKIP, CAPTURE, HOLD} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_vsync;
  logic        r_href;
  logic        r_phase;
  logic        r_wrEn;
  logic        r_full;
  logic        r_lineErr;
  logic        r_frameDone;
  logic        r_frameErr;
  logic [1:0]  r_skipCnt;
  logic [6:0]  r_hiBits;
  logic [15:0] r_byteCnt;
  logic [15:0] r_lineCnt;
  logic [16:0] r_wrAddr;
  logic [11:0] r_wrData;

  logic        w_vsyncRise;
  logic        w_vsyncFall;
  logic        w_lineEnd;
  logic        w_full;
  logic        w_lineErrNow;
  logic        w_frameGood;
  logic [15:0] w_lineCntNow;
  logic [11:0] w_pixel;
  logic        w_busy;
  logic        w_inCapture;
  logic        w_skipAdvance;
  logic        w_capEntry;
  logic        w_frameEnd;
  logic        w_takeByte;

  assign w_vsyncRise  = bus.cap_vsync & ~r_vsync;
  assign w_vsyncFall  = ~bus.cap_vsync & r_vsync;
  assign w_lineEnd    = r_href & ~bus.cap_href;
  // A write still in flight at the last address already counts as a full frame.
  assign w_full       = r_full | (r_wrEn & (r_wrAddr == ADDR_MAX));
  assign w_lineErrNow = r_lineErr | (w_lineEnd & (r_byteCnt != 16'(H_BYTES))) | bus.cap_href;
  assign w_lineCntNow = r_lineCnt + {15'd0, w_lineEnd};
  assign w_frameGood  = ~w_lineErrNow & (w_lineCntNow == 16'(V_LINES)) & w_full;
  assign w_pixel      = {r_hiBits, bus.cap_d[7], bus.cap_d[4:1]};

  always_ff @(posedge cap_pclk or posedge reg_conf_rst) begin
    if (reg_conf_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (!bus.reg_conf_finish) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:     w_nextState = WAIT_SOF;
        WAIT_SOF: if (w_vsyncFall) w_nextState = (r_skipCnt == 2'd0) ? CAPTURE : SKIP;
        SKIP:     if (w_vsyncRise) w_nextState = WAIT_SOF;
        CAPTURE:  if (w_vsyncRise) w_nextState = bus.single_shot ? HOLD : WAIT_SOF;
        HOLD:     if (bus.arm) w_nextState = WAIT_SOF;
        default:  w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy        = (r_state == CAPTURE);
    w_inCapture   = w_busy & bus.reg_conf_finish;
    w_skipAdvance = (r_state == WAIT_SOF) & bus.reg_conf_finish & w_vsyncFall;
    w_capEntry    = w_skipAdvance & (r_skipCnt == 2'd0);
    w_frameEnd    = w_inCapture & w_vsyncRise;
    w_takeByte    = w_inCapture & ~w_vsyncRise & bus.cap_href;
  end

  always_ff @(posedge cap_pclk or posedge reg_conf_rst) begin
    if (reg_conf_rst) begin
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_phase     <= 1'b0;
      r_wrEn      <= 1'b0;
      r_full      <= 1'b0;
      r_lineErr   <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;
      r_skipCnt   <= 2'd0;
      r_hiBits    <= 7'd0;
      r_byteCnt   <= 16'd0;
      r_lineCnt   <= 16'd0;
      r_wrAddr    <= 17'd0;
      r_wrData    <= 12'd0;
    end else begin
      r_vsync     <= bus.cap_vsync;
      r_href      <= bus.cap_href;
      r_wrEn      <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;

      if (w_skipAdvance) begin
        r_skipCnt <= (r_skipCnt == bus.frame_skip) ? 2'd0 : r_skipCnt + 2'd1;
      end

      // Address advances after each strobe and saturates at the last pixel.
      if (r_wrEn) begin
        if (r_wrAddr == ADDR_MAX) r_full <= 1'b1;
        else                      r_wrAddr <= r_wrAddr + 17'd1;
      end

      if (w_capEntry) begin
        r_wrAddr  <= 17'd0;
        r_full    <= 1'b0;
        r_lineCnt <= 16'd0;
        r_lineErr <= 1'b0;
        r_phase   <= 1'b0;
        r_byteCnt <= 16'd0;
      end else if (w_frameEnd) begin
        r_frameDone <= w_frameGood;
        r_frameErr  <= ~w_frameGood;
        r_phase     <= 1'b0;
        r_byteCnt   <= 16'd0;
      end else if (w_takeByte) begin
        r_byteCnt <= (r_byteCnt == 16'hFFFF) ? r_byteCnt : r_byteCnt + 16'd1;
        r_phase   <= ~r_phase;
        if (!r_phase) begin
          r_hiBits <= {bus.cap_d[7:4], bus.cap_d[2:0]};
        end else if (w_full) begin
          r_lineErr <= 1'b1;
        end else begin
          r_wrEn   <= 1'b1;
          r_wrData <= w_pixel;
        end
      end else if (w_inCapture) begin
        r_phase <= 1'b0;
        if (w_lineEnd) begin
          r_lineCnt <= (r_lineCnt == 16'hFFFF) ? r_lineCnt : r_lineCnt + 16'd1;
          r_byteCnt <= 16'd0;
          if (r_byteCnt != 16'(H_BYTES)) r_lineErr <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en      = r_wrEn;
  assign bus.wr_addr    = r_wrAddr;
  assign bus.wr_data    = r_wrData;
  assign bus.frame_done = r_frameDone;
  assign bus.frame_err  = r_frameErr;
  assign bus.busy       = w_busy;
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter H_BYTES, default 640, bytes per active line (2 bytes per pixel).
REQ-002 SHALL have parameter V_LINES, default 240, active lines per frame.
REQ-003 SHALL have port cap_pclk  input  1  camera pixel clock; all logic on its rising edge.
REQ-004 SHALL have port reg_conf_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port reg_conf_finish  input  1  camera register configuration complete (level).
REQ-006 SHALL have port cap_vsync  input  1  frame sync, high between frames.
REQ-007 SHALL have port cap_href  input  1  line valid.
REQ-008 SHALL have port cap_d  input  8  RGB565 byte stream, high byte first.
REQ-009 SHALL have port frame_skip  input  2  capture one frame of every frame_skip+1 frames.
REQ-010 SHALL have port single_shot  input  1  1 = stop after one captured frame.
REQ-011 SHALL have port arm  input  1  one-cycle pulse that restarts capture from HOLD.
REQ-012 SHALL have port wr_en  output  1  frame-buffer write strobe.
REQ-013 SHALL have port wr_addr  output  17  frame-buffer pixel address, 0..(H_BYTES/2*V_LINES-1).
REQ-014 SHALL have port wr_data  output  12  RGB444 pixel.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse on a good frame.
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-017 SHALL have port busy  output  1  high in CAPTURE state.

Function
REQ-018 SHALL implement states IDLE, WAIT_SOF, SKIP, CAPTURE, HOLD.
REQ-019 IDLE -> WAIT_SOF when reg_conf_finish is sampled high.
REQ-020 WAIT_SOF: on a cap_vsync falling edge (registered vsync 1, current 0), go to CAPTURE if skip_cnt==0, else to SKIP; then skip_cnt = (skip_cnt==frame_skip) ? 0 : skip_cnt+1.
REQ-021 SKIP -> WAIT_SOF on a cap_vsync rising edge; no writes in SKIP.
REQ-022 CAPTURE: on a cap_vsync rising edge, evaluate the frame (REQ-028), then go to HOLD if single_shot=1, else to WAIT_SOF.
REQ-023 HOLD -> WAIT_SOF on arm=1; arm is ignored in all other states.
REQ-024 In CAPTURE with cap_href=1, bytes SHALL alternate in phase: phase 0 latches the high byte, phase 1 completes a pixel; phase clears when cap_href=0.
REQ-025 Pixel SHALL be wr_data = {hi[7:4], hi[2:0], lo[7], lo[4:1]}.
REQ-026 wr_en SHALL pulse exactly one cycle after the phase-1 byte is sampled, with wr_addr/wr_data valid in that cycle; wr_addr SHALL then increment by 1.
REQ-027 wr_addr SHALL clear to 0 at every CAPTURE entry; line_cnt SHALL clear at entry and increment on each cap_href falling edge.
REQ-028 Frame evaluation: frame_done=1 iff line_cnt==V_LINES, pixel count==H_BYTES/2*V_LINES and no line error; otherwise frame_err=1; never both.
REQ-029 Line error SHALL be set when a line's byte count != H_BYTES (odd counts included); the dangling high byte of an odd line SHALL be discarded without a write.
REQ-030 When wr_addr reaches its maximum, further pixels SHALL be dropped (no wr_en, no wrap) and a line error SHALL be set.
REQ-031 A cap_vsync rise while cap_href=1 SHALL abort the line, count it as short (error), and perform no partial write.
REQ-032 reg_conf_finish falling in any state SHALL force IDLE on the next edge with no done/err pulse.
REQ-033 frame_done/frame_err SHALL fire in the cycle after the vsync rising edge is detected.

Reset
REQ-034 On reg_conf_rst=1: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0, busy=0, skip_cnt=0, phase=0, line_cnt=0, error flag=0, registered vsync=0, all asynchronously.
REQ-035 A reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for reg_conf_finish and a fresh vsync falling edge.

Verification
REQ-036 Normal frame, 240 lines of 640 bytes, hi=0xF8 lo=0x1F -> 76800 wr_en pulses, wr_data=0xF0F, last wr_addr=76799, one frame_done, no frame_err.
REQ-037 frame_skip=2, 6 frames -> only frames 1 and 4 are written; exactly 2 frame_done pulses.
REQ-038 Line 10 of 639 bytes -> no write for the dangling byte, frame_err at end of frame, no frame_done.
REQ-039 single_shot=1 -> one frame_done then HOLD, no writes for 2 frames; arm pulse -> next frame captured.
REQ-040 Reset at line 100 of capture -> outputs 0 immediately; next frame after reg_conf_finish starts at wr_addr=0.
REQ-041 241 lines of 640 bytes -> writes stop at wr_addr=76799, frame_err pulse.
